// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation zone scheduler.
// Holds the FSM/mode encodings, default run lengths and probe helper functions.
package irrigation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_ERROR    = 3'd3
    } state_t;

    typedef enum logic {
        MODE_DRIPPER   = 1'b0,
        MODE_SPRINKLER = 1'b1
    } mode_t;

    localparam int DEFAULT_SPRINKLER_TICKS = 120;
    localparam int DEFAULT_DRIPPER_TICKS   = 240;

    // Reservoir probes are stacked, so a higher probe wet above a dry lower one is impossible.
    function automatic logic probe_conflict(input logic low, input logic mid, input logic high);
        return (high & ~mid) | (mid & ~low) | (high & ~low);
    endfunction

    function automatic mode_t select_mode(input logic mid, input logic air, input logic cold);
        return (mid & ~air & ~cold) ? MODE_SPRINKLER : MODE_DRIPPER;
    endfunction

endpackage

// File: rtl/zone_arbiter.sv
// Round-robin picker: returns the first dry zone found after the last-served zone.
// Purely combinational; the caller owns the last-served pointer.
module zone_arbiter #(
    parameter int ZONES = 4,
    parameter int ZW    = $clog2(ZONES)
) (
    input  logic [ZONES-1:0] dry,
    input  logic [ZW-1:0]    last_zone,
    output logic [ZW-1:0]    grant,
    output logic             grant_valid
);

    // The last-served zone itself is examined last, so it only wins when it is the sole dry zone.
    always_comb begin
        int idx;
        logic [ZW-1:0] sel;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int i = 1; i <= ZONES; i++) begin
            idx = int'(last_zone) + i;
            if (idx >= ZONES) begin
                idx = idx - ZONES;
            end
            sel = ZW'(idx);
            if (!grant_valid && dry[sel]) begin
                grant       = sel;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation scheduler: serves dry zones one at a time in round-robin order,
// running either a sprinkler pump or a dripper valve for a tick-counted interval.
module irrigation_zone_scheduler
    import irrigation_pkg::*;
#(
    parameter int ZONES           = 4,
    parameter int TIME_W          = 8,
    parameter int SPRINKLER_TICKS = DEFAULT_SPRINKLER_TICKS,
    parameter int DRIPPER_TICKS   = DEFAULT_DRIPPER_TICKS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     low_water_level,
    input  logic                     mid_water_level,
    input  logic                     high_water_level,
    input  logic [ZONES-1:0]         earth_humidity,
    input  logic                     air_humidity,
    input  logic                     low_temperature,
    output logic [ZONES-1:0]         splinker_bomb,
    output logic [ZONES-1:0]         dripper_valvule,
    output logic                     water_supply_valvule,
    output logic                     alarm,
    output logic                     conflicting_values,
    output logic [$clog2(ZONES)-1:0] active_zone,
    output logic [TIME_W-1:0]        remaining,
    output logic [2:0]               state
);

    localparam int ZW = $clog2(ZONES);

    logic             tick_q;
    logic             low_q;
    logic             mid_q;
    logic             high_q;
    logic             air_q;
    logic             cold_q;
    logic [ZONES-1:0] earth_q;

    state_t           cur_state;
    state_t           next_state;
    mode_t            mode_q;
    logic [ZW-1:0]    cur_zone;
    logic [ZW-1:0]    last_zone;

    logic             conflict_now;
    logic [ZONES-1:0] dry;
    logic [ZONES-1:0] zone_onehot;
    logic             cur_wet;
    logic             other_dry;
    logic             run_done;
    logic [ZW-1:0]    grant;
    logic             grant_valid;

    logic             load_run;
    logic             clear_run;
    logic             count_tick;

    // Every input passes through one register; all decisions below use the registered copies.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q  <= 1'b0;
            low_q   <= 1'b0;
            mid_q   <= 1'b0;
            high_q  <= 1'b0;
            air_q   <= 1'b0;
            cold_q  <= 1'b0;
            earth_q <= '0;
        end else begin
            tick_q  <= tick;
            low_q   <= low_water_level;
            mid_q   <= mid_water_level;
            high_q  <= high_water_level;
            air_q   <= air_humidity;
            cold_q  <= low_temperature;
            earth_q <= earth_humidity;
        end
    end

    assign conflict_now = probe_conflict(low_q, mid_q, high_q);
    assign dry          = ~earth_q;
    assign zone_onehot  = {{(ZONES-1){1'b0}}, 1'b1} << cur_zone;
    assign cur_wet      = earth_q[cur_zone];
    assign other_dry    = |(dry & ~zone_onehot);
    assign run_done     = (remaining == '0) || cur_wet;

    zone_arbiter #(
        .ZONES (ZONES),
        .ZW    (ZW)
    ) u_zone_arbiter (
        .dry         (dry),
        .last_zone   (last_zone),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // A termination condition always beats a coincident tick, so the count freezes on exit.
    always_comb begin
        next_state = cur_state;
        load_run   = 1'b0;
        clear_run  = 1'b0;
        count_tick = 1'b0;
        if (conflict_now) begin
            next_state = ST_ERROR;
            clear_run  = 1'b1;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (low_q && (|dry)) begin
                        next_state = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (low_q && grant_valid) begin
                        next_state = ST_IRRIGATE;
                        load_run   = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                        clear_run  = 1'b1;
                    end
                end
                ST_IRRIGATE: begin
                    if (!low_q) begin
                        next_state = ST_IDLE;
                        clear_run  = 1'b1;
                    end else if (run_done) begin
                        if (other_dry) begin
                            next_state = ST_SELECT;
                        end else begin
                            next_state = ST_IDLE;
                            clear_run  = 1'b1;
                        end
                    end else if (tick_q) begin
                        count_tick = 1'b1;
                    end
                end
                ST_ERROR: begin
                    next_state = ST_IDLE;
                    clear_run  = 1'b1;
                end
                default: begin
                    next_state = ST_IDLE;
                    clear_run  = 1'b1;
                end
            endcase
        end
    end

    // Mode and zone are latched only when a run is loaded, so climate changes cannot alter a run.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining            <= '0;
            cur_zone             <= '0;
            last_zone            <= ZW'(ZONES - 1);
            mode_q               <= MODE_DRIPPER;
            conflicting_values   <= 1'b0;
            water_supply_valvule <= 1'b0;
            alarm                <= 1'b0;
        end else begin
            conflicting_values   <= conflict_now;
            water_supply_valvule <= ~high_q & ~conflict_now;
            alarm                <= conflict_now | ~mid_q;
            if (load_run) begin
                cur_zone  <= grant;
                last_zone <= grant;
                mode_q    <= select_mode(mid_q, air_q, cold_q);
                if (select_mode(mid_q, air_q, cold_q) == MODE_SPRINKLER) begin
                    remaining <= TIME_W'(SPRINKLER_TICKS);
                end else begin
                    remaining <= TIME_W'(DRIPPER_TICKS);
                end
            end else if (clear_run) begin
                remaining <= '0;
            end else if (count_tick && (remaining != '0)) begin
                remaining <= remaining - TIME_W'(1);
            end
        end
    end

    always_comb begin
        splinker_bomb   = '0;
        dripper_valvule = '0;
        active_zone     = '0;
        if (cur_state == ST_IRRIGATE) begin
            active_zone = cur_zone;
            if (mode_q == MODE_SPRINKLER) begin
                splinker_bomb = zone_onehot;
            end else begin
                dripper_valvule = zone_onehot;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Self-checking bench for irrigation_zone_scheduler: directed scenarios plus a
// randomized round-robin section predicted from the zone-ordering and run-length rules.
module tb_irrigation_zone_scheduler;
    import irrigation_pkg::*;

    localparam int ZONES  = 4;
    localparam int TIME_W = 8;
    localparam int SPR    = 120;
    localparam int DRP    = 240;

    logic             clock = 1'b0;
    logic             reset;
    logic             tick;
    logic             low_water_level;
    logic             mid_water_level;
    logic             high_water_level;
    logic [ZONES-1:0] earth_humidity;
    logic             air_humidity;
    logic             low_temperature;
    logic [ZONES-1:0] splinker_bomb;
    logic [ZONES-1:0] dripper_valvule;
    logic             water_supply_valvule;
    logic             alarm;
    logic             conflicting_values;
    logic [1:0]       active_zone;
    logic [TIME_W-1:0] remaining;
    logic [2:0]       state;

    int               checks = 0;
    int               errors = 0;
    int               cur_zone;
    int               cur_left;
    int               exp_zone;
    int               exp_len;
    int               k;
    bit               exp_spr;
    logic             r_mid;
    logic             r_air;
    logic             r_cold;
    logic [ZONES-1:0] dry_mask;

    irrigation_zone_scheduler #(
        .ZONES           (ZONES),
        .TIME_W          (TIME_W),
        .SPRINKLER_TICKS (SPR),
        .DRIPPER_TICKS   (DRP)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .tick                 (tick),
        .low_water_level      (low_water_level),
        .mid_water_level      (mid_water_level),
        .high_water_level     (high_water_level),
        .earth_humidity       (earth_humidity),
        .air_humidity         (air_humidity),
        .low_temperature      (low_temperature),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .water_supply_valvule (water_supply_valvule),
        .alarm                (alarm),
        .conflicting_values   (conflicting_values),
        .active_zone          (active_zone),
        .remaining            (remaining),
        .state                (state)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic low, input logic mid, input logic high,
                                 input logic air, input logic cold, input logic [ZONES-1:0] earth);
        low_water_level  = low;
        mid_water_level  = mid;
        high_water_level = high;
        air_humidity     = air;
        low_temperature  = cold;
        earth_humidity   = earth;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic await_state(input string tag, input logic [2:0] want, input int budget);
        int n = 0;
        while (state !== want && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, state, want);
    endtask

    function automatic int next_dry(input logic [ZONES-1:0] mask, input int last);
        for (int i = 1; i <= ZONES; i++) begin
            int z = (last + i) % ZONES;
            if (mask[z]) return z;
        end
        return -1;
    endfunction

    task automatic check_run(input string tag, input int zone, input bit spr, input int len);
        logic [ZONES-1:0] hot;
        hot = '0;
        hot[zone] = 1'b1;
        checkOutput({tag, "_zone"}, active_zone, zone);
        checkOutput({tag, "_spr"}, splinker_bomb, spr ? hot : {ZONES{1'b0}});
        checkOutput({tag, "_drp"}, dripper_valvule, spr ? {ZONES{1'b0}} : hot);
        checkOutput({tag, "_rem"}, remaining, len);
    endtask

    task automatic start_run(input string tag, input int zone, input bit spr, input int len);
        await_state({tag, "_sel"}, ST_SELECT, 20);
        await_state({tag, "_irr"}, ST_IRRIGATE, 4);
        check_run(tag, zone, spr, len);
    endtask

    task automatic check_quiet(input string tag);
        checkOutput({tag, "_state"}, state, ST_IDLE);
        checkOutput({tag, "_spr"}, splinker_bomb, 0);
        checkOutput({tag, "_drp"}, dripper_valvule, 0);
        checkOutput({tag, "_zone"}, active_zone, 0);
        checkOutput({tag, "_rem"}, remaining, 0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '1);
        settle(3);
        check_quiet("reset");
        checkOutput("reset_water", water_supply_valvule, 0);
        checkOutput("reset_alarm", alarm, 0);
        checkOutput("reset_conf", conflicting_values, 0);

        // All zones dry, sprinkler climate: zone 0 first, full countdown, then zone 1.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        reset = 1'b0;
        start_run("s1", 0, 1'b1, SPR);
        for (int n = 1; n <= SPR; n++) begin
            if (n == 20) air_humidity = 1'b1;
            if (n == 30) air_humidity = 1'b0;
            settle($urandom_range(0, 2));
            pulse_tick();
            checkOutput($sformatf("s1_rem%0d", n), remaining, SPR - n);
            if (n == 25) checkOutput("s1_mode_held", splinker_bomb, 4'b0001);
        end
        checkOutput("s1_at_zero", state, ST_IRRIGATE);
        start_run("s1_next", 1, 1'b1, SPR);
        cur_zone = 1;
        cur_left = SPR;
        dry_mask = '1;

        // Randomized hand-offs predicted from round-robin order and climate.
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, 3);
            for (int t = 0; t < k; t++) begin
                pulse_tick();
                cur_left--;
                checkOutput($sformatf("rr%0d_tick", r), remaining, cur_left);
            end
            r_mid  = 1'($urandom_range(0, 1));
            r_air  = 1'($urandom_range(0, 1));
            r_cold = 1'($urandom_range(0, 1));
            dry_mask = dry_mask | ZONES'($urandom);
            dry_mask[cur_zone] = 1'b0;
            if (dry_mask == '0) dry_mask[(cur_zone + 1) % ZONES] = 1'b1;
            exp_zone = next_dry(dry_mask, cur_zone);
            exp_spr  = r_mid & ~r_air & ~r_cold;
            exp_len  = exp_spr ? SPR : DRP;
            applyStimulus(1'b1, r_mid, 1'b0, r_air, r_cold, ~dry_mask);
            start_run($sformatf("rr%0d", r), exp_zone, exp_spr, exp_len);
            cur_zone = exp_zone;
            cur_left = exp_len;
        end

        // Everything wet ends the run with nowhere to go.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '1);
        await_state("all_wet", ST_IDLE, 10);

        // Only zone 2 dry with humid air: dripper run, then the zone turns wet.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011);
        start_run("drip", 2, 1'b0, DRP);
        for (int n = 1; n <= 10; n++) begin
            pulse_tick();
        end
        checkOutput("drip_rem10", remaining, DRP - 10);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '1);
        settle(2);
        check_quiet("drip_end");

        // Tick arriving together with the wet reading is dropped; next zone takes over.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100);
        start_run("coin", 0, 1'b1, SPR);
        repeat (3) pulse_tick();
        checkOutput("coin_rem", remaining, SPR - 3);
        tick = 1'b1;
        earth_humidity = 4'b1101;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
        checkOutput("coin_state", state, ST_SELECT);
        checkOutput("coin_frozen", remaining, SPR - 3);
        @(negedge clock);
        checkOutput("coin_next_state", state, ST_IRRIGATE);
        check_run("coin_next", 1, 1'b1, SPR);

        // Probe conflict mid-run forces ERROR, then recovery.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1101);
        settle(2);
        checkOutput("err_state", state, ST_ERROR);
        checkOutput("err_conf", conflicting_values, 1);
        checkOutput("err_alarm", alarm, 1);
        checkOutput("err_spr", splinker_bomb, 0);
        checkOutput("err_drp", dripper_valvule, 0);
        checkOutput("err_water", water_supply_valvule, 0);
        checkOutput("err_zone", active_zone, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
        settle(1);
        checkOutput("err_hold", state, ST_ERROR);
        settle(1);
        checkOutput("err_exit", state, ST_IDLE);
        checkOutput("err_conf_clr", conflicting_values, 0);
        checkOutput("err_alarm_clr", alarm, 0);

        // Reservoir empties at remaining=50.
        start_run("low", 1, 1'b1, SPR);
        repeat (SPR - 50) pulse_tick();
        checkOutput("low_rem50", remaining, 50);
        checkOutput("low_water_on", water_supply_valvule, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101);
        settle(2);
        check_quiet("low_end");
        checkOutput("low_water_after", water_supply_valvule, 1);
        checkOutput("low_alarm", alarm, 1);

        // Reset in the middle of a run at remaining=7.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
        start_run("rst", 1, 1'b1, SPR);
        repeat (SPR - 7) pulse_tick();
        checkOutput("rst_rem7", remaining, 7);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_quiet("rst_after");
        checkOutput("rst_water", water_supply_valvule, 0);
        checkOutput("rst_alarm", alarm, 0);
        checkOutput("rst_conf", conflicting_values, 0);
        @(negedge clock);
        reset = 1'b0;
        settle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
